// File: rtl/acc_arb.sv
// Two-requester round-robin arbiter in front of a repeated-add accumulator.
// A granted job adds step to y cnt times, then pulses done with the owner id.
module acc_arb #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] step0,
  input  logic [W-1:0] cnt0,
  input  logic         req1,
  input  logic [W-1:0] step1,
  input  logic [W-1:0] cnt1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic         rr_q;
  logic         owner_q;
  logic [W-1:0] step_q;
  logic [W-1:0] rem_q;
  logic [W-1:0] y_q;
  logic         gnt0_q;
  logic         gnt1_q;
  logic         busy_q;
  logic         done_q;
  logic         done_id_q;

  logic         pick1_d;
  logic [W-1:0] sel_step_d;
  logic [W-1:0] sel_cnt_d;
  logic [W-1:0] y_sum_d;

  // rr_q == 1 means requester 1 wins a tie
  assign pick1_d    = req1 & (~req0 | rr_q);
  assign sel_step_d = pick1_d ? step1 : step0;
  assign sel_cnt_d  = pick1_d ? cnt1 : cnt0;
  assign y_sum_d    = y_q + step_q;

  // DONE is the last busy cycle before the registered done pulse, so the
  // pulse lands cnt+1 cycles after the grant pulse and the done cycle is IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      step_q    <= '0;
      rem_q     <= '0;
      y_q       <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (req0 || req1) begin
            gnt0_q  <= ~pick1_d;
            gnt1_q  <= pick1_d;
            owner_q <= pick1_d;
            rr_q    <= ~pick1_d;
            step_q  <= sel_step_d;
            rem_q   <= sel_cnt_d;
            y_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= (sel_cnt_d == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          y_q   <= y_sum_d;
          rem_q <= rem_q - W'(1);
          if (rem_q == W'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q    <= 1'b1;
          done_id_q <= owner_q;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign y       = y_q;

endmodule

// File: tb/tb_acc_arb.sv
// Scoreboard bench for acc_arb: stimulus queues expected jobs in grant order,
// a negedge monitor matches each grant and done pulse against the queue head.
module tb_acc_arb;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] step0, cnt0, step1, cnt1;
  logic         gnt0, gnt1, busy, done, done_id;
  logic [W-1:0] y;

  acc_arb #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .step0(step0), .cnt0(cnt0),
    .req1(req1), .step1(step1), .cnt1(cnt1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           id;
    logic [W-1:0] y;
    int           cnt;
  } job_t;

  job_t exp_q[$];
  job_t cur;
  bit   cur_valid = 1'b0;
  int   gnt_cyc   = 0;
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected or never seen (cycle %0d)", name, cyc);
  endfunction

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      cur_valid = 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", longint'(gnt0 & gnt1), 0);
        if (exp_q.size() == 0) begin
          fail("unexpected_gnt");
        end else begin
          cur       = exp_q.pop_front();
          cur_valid = 1'b1;
          gnt_cyc   = cyc;
          chk("gnt_id", longint'(gnt1), longint'(cur.id));
          chk("busy_at_gnt", longint'(busy), 1);
        end
      end
      if (done) begin
        if (!cur_valid) begin
          fail("unexpected_done");
        end else begin
          chk("done_y", longint'(y), longint'(cur.y));
          chk("done_id", longint'(done_id), longint'(cur.id));
          chk("done_latency", longint'(cyc - gnt_cyc), longint'(cur.cnt + 1));
          chk("busy_at_done", longint'(busy), 1);
          cur_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input bit id, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) begin
        at = cyc;
        return;
      end
    end
    fail(id ? "timeout_gnt1" : "timeout_gnt0");
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        return;
      end
    end
    fail("timeout_done");
  endtask

  task automatic push(input bit id, input int yv, input int c);
    job_t j;
    j.id  = id;
    j.y   = W'(yv);
    j.cnt = c;
    exp_q.push_back(j);
  endtask

  initial begin
    int g, d, g0, d0, g1, n_done;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    step0 = '0; cnt0 = '0; step1 = '0; cnt1 = '0;
    tick(3);
    chk("reset_outputs", longint'({gnt0, gnt1, busy, done, done_id, y}), 0);
    reset = 1'b0;
    tick(2);
    chk("idle_no_req", longint'({gnt0, gnt1, busy, done}), 0);

    // long job, operands change after grant
    step0 = 8'd1; cnt0 = 8'd255;
    push(1'b0, 255, 255);
    req0 = 1'b1;
    wait_gnt(1'b0, 10, g);
    req0 = 1'b0; step0 = 8'hAA; cnt0 = 8'd3;
    wait_done(300, d);
    tick(1);

    // wrapping job on requester 1
    step1 = 8'd3; cnt1 = 8'd100;
    push(1'b1, 44, 100);
    req1 = 1'b1;
    wait_gnt(1'b1, 10, g);
    req1 = 1'b0;
    wait_done(200, d);
    tick(1);

    // zero-count job: done next cycle, busy for exactly two cycles
    step0 = 8'd9; cnt0 = 8'd0;
    push(1'b0, 0, 0);
    req0 = 1'b1;
    wait_gnt(1'b0, 10, g);
    req0 = 1'b0;
    tick(1);
    chk("cnt0_done_next", longint'(done), 1);
    chk("cnt0_busy_2nd", longint'(busy), 1);
    tick(1);
    chk("cnt0_busy_off", longint'(busy), 0);

    // request pulsed and dropped while busy is never granted
    step0 = 8'd2; cnt0 = 8'd10;
    push(1'b0, 20, 10);
    req0 = 1'b1;
    wait_gnt(1'b0, 10, g);
    req0 = 1'b0;
    tick(2);
    req1 = 1'b1;
    tick(3);
    req1 = 1'b0;
    wait_done(30, d);
    tick(15);
    chk("idle_after_drop", longint'(busy), 0);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;

    // tie after reset: 0 first, 1 waits and is granted right after done
    step0 = 8'd5; cnt0 = 8'd2; step1 = 8'd7; cnt1 = 8'd2;
    push(1'b0, 10, 2);
    push(1'b1, 14, 2);
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(1'b0, 10, g0);
    req0 = 1'b0;
    wait_done(10, d0);
    wait_gnt(1'b1, 10, g1);
    chk("gnt1_gap_after_done", longint'(g1 - d0), 1);
    req1 = 1'b0;
    wait_done(10, d);
    tick(1);
    push(1'b0, 10, 2);
    push(1'b1, 14, 2);
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(1'b0, 10, g0);
    req0 = 1'b0;
    wait_gnt(1'b1, 20, g1);
    req1 = 1'b0;
    wait_done(10, d);
    tick(1);

    // reset four cycles into a job aborts it and restores rr to 0
    step0 = 8'd1; cnt0 = 8'd50;
    push(1'b0, 50, 50);
    req0 = 1'b1;
    wait_gnt(1'b0, 10, g);
    req0 = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("abort_outputs", longint'({gnt0, gnt1, busy, done, done_id, y}), 0);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (done) n_done++;
    end
    chk("abort_no_done", longint'(n_done), 0);
    step0 = 8'd2; cnt0 = 8'd3; step1 = 8'd1; cnt1 = 8'd1;
    push(1'b0, 6, 3);
    push(1'b1, 1, 1);
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(1'b0, 10, g0);
    req0 = 1'b0;
    wait_gnt(1'b1, 20, g1);
    req1 = 1'b0;
    wait_done(10, d);
    tick(5);
    chk("queue_drained", longint'(exp_q.size()), 0);
    chk("no_job_pending", longint'(cur_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
